// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath/memory bundle: IR opcode, branch condition, memory handshake,
// datapath enables, sticky status flags and performance counters.
interface multicycle_controller_if #(
    parameter int OPCODE_W = 6,
    parameter int CNT_W    = 32
);
    logic [OPCODE_W-1:0] opcode;
    logic                branch_taken;
    logic                mem_ready;
    logic                mem_req;
    logic                mem_we;
    logic                ir_write;
    logic                pc_write;
    logic                pc_src;
    logic [2:0]          alu_op;
    logic                reg_write;
    logic                mem2reg;
    logic                instr_done;
    logic                halted;
    logic                illegal;
    logic                bus_err;
    logic [CNT_W-1:0]    cycle_cnt;
    logic [CNT_W-1:0]    instr_cnt;

    modport master (
        input  opcode, branch_taken, mem_ready,
        output mem_req, mem_we, ir_write, pc_write, pc_src, alu_op, reg_write, mem2reg,
               instr_done, halted, illegal, bus_err, cycle_cnt, instr_cnt
    );

    modport slave (
        output opcode, branch_taken, mem_ready,
        input  mem_req, mem_we, ir_write, pc_write, pc_src, alu_op, reg_write, mem2reg,
               instr_done, halted, illegal, bus_err, cycle_cnt, instr_cnt
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with bounded memory wait and fault traps.
// Define MC_PERF_CNT_EN to build the saturating cycle / retired-instruction counters.
module multicycle_controller #(
    parameter int OPCODE_W    = 6,
    parameter int NUM_OPS     = 15,
    parameter int LD_OP       = 3,
    parameter int ST_OP       = 4,
    parameter int HALT_OP     = NUM_OPS - 1,
    parameter int BR_FIRST    = 5,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    multicycle_controller_if.master bus
);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_TRAP
    } state_e;

    state_e              state_q, state_d;
    logic [OPCODE_W-1:0] op_q, op_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                halted_q, halted_d;
    logic                illegal_q, illegal_d;
    logic                bus_err_q, bus_err_d;

    logic       mem_req, mem_we, ir_write, pc_write, pc_src, reg_write, mem2reg, instr_done;
    logic [2:0] alu_op;
    logic       is_ld, is_st, is_br, timeout;

    assign is_ld   = int'(op_q) == LD_OP;
    assign is_st   = int'(op_q) == ST_OP;
    assign is_br   = (int'(op_q) >= BR_FIRST) && (int'(op_q) <= NUM_OPS - 2);
    assign timeout = wait_q == WAIT_W'(MEM_TIMEOUT - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            op_q      <= '0;
            wait_q    <= '0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            wait_q    <= wait_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        wait_d     = '0;
        halted_d   = halted_q;
        illegal_d  = illegal_q;
        bus_err_d  = bus_err_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        alu_op     = 3'b000;
        reg_write  = 1'b0;
        mem2reg    = 1'b0;
        instr_done = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (bus.mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                op_d = bus.opcode;
                if (int'(bus.opcode) >= NUM_OPS) begin
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end else if (int'(bus.opcode) == HALT_OP) begin
                    state_d    = S_HALT;
                    halted_d   = 1'b1;
                    instr_done = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_ld || is_st) begin
                    state_d = S_MEM;
                end else if (is_br) begin
                    pc_write   = bus.branch_taken;
                    pc_src     = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end else begin
                    alu_op  = op_q[2:0];
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = is_st;
                if (bus.mem_ready) begin
                    if (is_st) begin
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem2reg    = is_ld;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            default: ;
        endcase
        // Ready on the final allowed cycle still wins over the timeout.
        if (mem_req && !bus.mem_ready) begin
            if (timeout) begin
                state_d   = S_TRAP;
                bus_err_d = 1'b1;
            end else begin
                wait_d = wait_q + WAIT_W'(1);
            end
        end
        if (rst) begin
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            pc_src     = 1'b0;
            alu_op     = 3'b000;
            reg_write  = 1'b0;
            mem2reg    = 1'b0;
            instr_done = 1'b0;
        end
    end

    assign bus.mem_req    = mem_req;
    assign bus.mem_we     = mem_we;
    assign bus.ir_write   = ir_write;
    assign bus.pc_write   = pc_write;
    assign bus.pc_src     = pc_src;
    assign bus.alu_op     = alu_op;
    assign bus.reg_write  = reg_write;
    assign bus.mem2reg    = mem2reg;
    assign bus.instr_done = instr_done;
    assign bus.halted     = halted_q & ~rst;
    assign bus.illegal    = illegal_q & ~rst;
    assign bus.bus_err    = bus_err_q & ~rst;

`ifdef MC_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_cnt_q, instr_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            if (state_q != S_HALT && state_q != S_TRAP && cycle_cnt_q != '1)
                cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
            if (instr_done && instr_cnt_q != '1)
                instr_cnt_q <= instr_cnt_q + CNT_W'(1);
        end
    end

    assign bus.cycle_cnt = rst ? '0 : cycle_cnt_q;
    assign bus.instr_cnt = rst ? '0 : instr_cnt_q;
`else
    assign bus.cycle_cnt = {CNT_W{1'b0}};
    assign bus.instr_cnt = {CNT_W{1'b0}};
`endif
endmodule
